// File: rtl/mb8_sched.sv
// mb8_sched: round-robin front end that shares one pipelined carry-save multiplier
// among NREQ requesters, tagging each issue and returning the product to its owner.
module mb8_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [NREQ*2*WIDTH-1:0] rsp_p,
  output logic [WIDTH-1:0]        mx1,
  output logic [WIDTH-1:0]        my1,
  input  logic [2*WIDTH-1:0]      sum1,
  input  logic [2*WIDTH-1:0]      carry1,
  output logic                    busy
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PWD = 2 * WIDTH;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]      outstanding_q, outstanding_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [NREQ*PWD-1:0]  rsp_p_q, rsp_p_d;
  logic [WIDTH-1:0]     mx1_q, mx1_d;
  logic [WIDTH-1:0]     my1_q, my1_d;
  logic [LAT:0]         tag_v_q, tag_v_d;
  logic [LAT:0][PW-1:0] tag_q, tag_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] rsp_hs;
  logic            grant_v;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  int              arb_idx;
  logic            accept;
  logic [PWD-1:0]  product;
  logic            res_v;
  logic [PW-1:0]   res_tag;

  assign eligible = req_valid & ~outstanding_q;
  assign rsp_hs   = rsp_valid_q & rsp_ready;

  // Grant the first eligible index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(ptr_q) + k) % NREQ;
      cand    = PW'(arb_idx);
      if (!grant_v && eligible[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept = grant_v & rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Stage 0 of the tag pipeline travels alongside mx1/my1.
  always_comb begin
    ptr_d = ptr_q;
    mx1_d = '0;
    my1_d = '0;
    if (accept) begin
      ptr_d = (grant_idx == PW'(NREQ - 1)) ? {PW{1'b0}} : grant_idx + 1'b1;
      mx1_d = req_a[grant_idx*WIDTH +: WIDTH];
      my1_d = req_b[grant_idx*WIDTH +: WIDTH];
    end
    tag_v_d = {tag_v_q[LAT-1:0], accept};
    tag_d   = {tag_q[LAT-1:0], (accept ? grant_idx : {PW{1'b0}})};
  end

  assign res_v   = tag_v_q[LAT];
  assign res_tag = tag_q[LAT];
  assign product = sum1 + carry1;

  // A handshake frees a slot; an aligned resolve fills the owner's slot.
  always_comb begin
    outstanding_d = outstanding_q & ~rsp_hs;
    if (accept) outstanding_d[grant_idx] = 1'b1;
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_p_d     = rsp_p_q;
    if (res_v) begin
      rsp_valid_d[res_tag]          = 1'b1;
      rsp_p_d[res_tag*PWD +: PWD]   = product;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_p_q       <= '0;
      mx1_q         <= '0;
      my1_q         <= '0;
      tag_v_q       <= '0;
      tag_q         <= '0;
    end else begin
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_p_q       <= rsp_p_d;
      mx1_q         <= mx1_d;
      my1_q         <= my1_d;
      tag_v_q       <= tag_v_d;
      tag_q         <= tag_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign mx1       = mx1_q;
  assign my1       = my1_q;
  assign busy      = |outstanding_q;

endmodule
